// File: rtl/apb_master_bridge_if.sv
// -----------------------------------------------------------------------------
// apb_master_bridge_if
// Bundles the requester-side valid/ready request and response signals together
// with the APB bus driven by apb_master_bridge.
//
// Signal groups:
//   request  : req_valid_i, req_ready_o, req_addr_i, req_write_i, req_wdata_i
//   response : rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o
//   APB      : paddr, psel, penable, pwrite, pwdata, pready, prdata, pslverr
//
// Modports:
//   master : the bridge side (drives req_ready_o, rsp_*, APB control/data)
//   slave  : the environment side (requester plus APB peripheral)
// -----------------------------------------------------------------------------
interface apb_master_bridge_if #(
   parameter int ADDRESS_WIDTH = 5,
   parameter int DATA_WIDTH    = 32
);

   // Request channel
   logic                     req_valid_i;
   logic                     req_ready_o;
   logic [ADDRESS_WIDTH-1:0] req_addr_i;
   logic                     req_write_i;
   logic [DATA_WIDTH-1:0]    req_wdata_i;

   // Response channel
   logic                     rsp_valid_o;
   logic [DATA_WIDTH-1:0]    rsp_rdata_o;
   logic                     rsp_err_o;
   logic                     rsp_timeout_o;

   // APB bus
   logic [ADDRESS_WIDTH-1:0] paddr;
   logic                     psel;
   logic                     penable;
   logic                     pwrite;
   logic [DATA_WIDTH-1:0]    pwdata;
   logic                     pready;
   logic [DATA_WIDTH-1:0]    prdata;
   logic                     pslverr;

   modport master (
      input  req_valid_i,
      output req_ready_o,
      input  req_addr_i,
      input  req_write_i,
      input  req_wdata_i,
      output rsp_valid_o,
      output rsp_rdata_o,
      output rsp_err_o,
      output rsp_timeout_o,
      output paddr,
      output psel,
      output penable,
      output pwrite,
      output pwdata,
      input  pready,
      input  prdata,
      input  pslverr
   );

   modport slave (
      output req_valid_i,
      input  req_ready_o,
      output req_addr_i,
      output req_write_i,
      output req_wdata_i,
      input  rsp_valid_o,
      input  rsp_rdata_o,
      input  rsp_err_o,
      input  rsp_timeout_o,
      input  paddr,
      input  psel,
      input  penable,
      input  pwrite,
      input  pwdata,
      output pready,
      output prdata,
      output pslverr
   );

endinterface : apb_master_bridge_if

// File: rtl/apb_master_bridge.sv
// -----------------------------------------------------------------------------
// apb_master_bridge
// Single-outstanding APB requester. A request accepted on the valid/ready port
// becomes one APB SETUP + ACCESS transfer; completion is reported on a
// one-cycle response pulse carrying read data, slave error and timeout status.
// A wait-state timeout aborts transfers whose slave never raises pready.
//
// Ports:
//   pclk    : clock
//   presetn : asynchronous active-low reset; drops psel/penable immediately
//   bus     : apb_master_bridge_if.master (request, response and APB signals)
//
// Parameters:
//   ADDRESS_WIDTH  : address width (req_addr_i / paddr)
//   DATA_WIDTH     : data path width
//   TIMEOUT_CYCLES : ACCESS cycles with pready low before abort, 0 = never
//   CNT_WIDTH      : wait counter width, TIMEOUT_CYCLES must be < 2**CNT_WIDTH
// -----------------------------------------------------------------------------
module apb_master_bridge #(
   parameter int ADDRESS_WIDTH  = 5,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_WIDTH      = 8
) (
   input  logic               pclk,
   input  logic               presetn,
   apb_master_bridge_if.master bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_t;

   localparam bit                   TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
   // Counter value seen in the last permitted ACCESS cycle (count starts at 0)
   localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX      = {CNT_WIDTH{1'b1}};

   state_t                   state_r;
   state_t                   state_s;

   logic [ADDRESS_WIDTH-1:0] paddr_r;
   logic                     pwrite_r;
   logic [DATA_WIDTH-1:0]    pwdata_r;
   logic [CNT_WIDTH-1:0]     wait_cnt_r;

   logic                     rsp_valid_r;
   logic [DATA_WIDTH-1:0]    rsp_rdata_r;
   logic                     rsp_err_r;
   logic                     rsp_timeout_r;

   logic                     req_ready_s;
   logic                     psel_s;
   logic                     penable_s;
   logic                     accept_s;
   logic                     timeout_hit_s;
   logic                     done_ok_s;
   logic                     done_to_s;

   // Transfer events derived from registered state and bus inputs
   always_comb begin
      accept_s      = (state_r == ST_IDLE) && bus.req_valid_i;
      timeout_hit_s = TIMEOUT_EN && (wait_cnt_r == TIMEOUT_LAST);
      // pready has priority over a timeout landing in the same cycle
      done_ok_s     = (state_r == ST_ACCESS) && bus.pready;
      done_to_s     = (state_r == ST_ACCESS) && !bus.pready && timeout_hit_s;
   end

   // FSM state register
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.req_valid_i) begin
               state_s = ST_SETUP;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SETUP: begin
            state_s = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (done_ok_s || done_to_s) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_ACCESS;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // FSM output decode; depends on the state register only, so reset
   // deasserts psel/penable without waiting for a clock edge
   always_comb begin
      req_ready_s = 1'b0;
      psel_s      = 1'b0;
      penable_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            req_ready_s = 1'b1;
         end
         ST_SETUP: begin
            psel_s = 1'b1;
         end
         ST_ACCESS: begin
            psel_s    = 1'b1;
            penable_s = 1'b1;
         end
         default: begin
            req_ready_s = 1'b0;
         end
      endcase
   end

   // Request capture; held through the transfer and kept afterwards in IDLE
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         paddr_r  <= {ADDRESS_WIDTH{1'b0}};
         pwrite_r <= 1'b0;
         pwdata_r <= {DATA_WIDTH{1'b0}};
      end else if (accept_s) begin
         paddr_r  <= bus.req_addr_i;
         pwrite_r <= bus.req_write_i;
         pwdata_r <= bus.req_wdata_i;
      end else begin
         paddr_r  <= paddr_r;
         pwrite_r <= pwrite_r;
         pwdata_r <= pwdata_r;
      end
   end

   // Wait-state counter: cleared on entering SETUP, saturates instead of wrapping
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         wait_cnt_r <= {CNT_WIDTH{1'b0}};
      end else if (accept_s) begin
         wait_cnt_r <= {CNT_WIDTH{1'b0}};
      end else if ((state_r == ST_ACCESS) && !bus.pready && (wait_cnt_r != CNT_MAX)) begin
         wait_cnt_r <= wait_cnt_r + CNT_WIDTH'(1);
      end else begin
         wait_cnt_r <= wait_cnt_r;
      end
   end

   // Response pulse, asserted in the first IDLE cycle after completion
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         rsp_valid_r <= 1'b0;
      end else begin
         rsp_valid_r <= done_ok_s || done_to_s;
      end
   end

   // Response payload; holds until the next completion
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         rsp_rdata_r   <= {DATA_WIDTH{1'b0}};
         rsp_err_r     <= 1'b0;
         rsp_timeout_r <= 1'b0;
      end else if (done_ok_s) begin
         rsp_rdata_r   <= pwrite_r ? {DATA_WIDTH{1'b0}} : bus.prdata;
         rsp_err_r     <= bus.pslverr;
         rsp_timeout_r <= 1'b0;
      end else if (done_to_s) begin
         rsp_rdata_r   <= {DATA_WIDTH{1'b0}};
         rsp_err_r     <= 1'b1;
         rsp_timeout_r <= 1'b1;
      end else begin
         rsp_rdata_r   <= rsp_rdata_r;
         rsp_err_r     <= rsp_err_r;
         rsp_timeout_r <= rsp_timeout_r;
      end
   end

   assign bus.req_ready_o   = req_ready_s;
   assign bus.psel          = psel_s;
   assign bus.penable       = penable_s;
   assign bus.paddr         = paddr_r;
   assign bus.pwrite        = pwrite_r;
   assign bus.pwdata        = pwdata_r;
   assign bus.rsp_valid_o   = rsp_valid_r;
   assign bus.rsp_rdata_o   = rsp_rdata_r;
   assign bus.rsp_err_o     = rsp_err_r;
   assign bus.rsp_timeout_o = rsp_timeout_r;

endmodule : apb_master_bridge

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Single-outstanding APB requester: converts a valid/ready request port from the core or bus fabric into APB SETUP/ACCESS transfers.
- Drives the SoC APB peripherals (GPIO and others).
- Returns read data and error status on a one-cycle response pulse.
- A programmable wait-state timeout aborts hung transfers, so an unresponsive slave cannot stall the requester.

Parameters:
ADDRESS_WIDTH, 5, width of req_addr_i / paddr
DATA_WIDTH, 32, width of data paths
TIMEOUT_CYCLES, 16, maximum ACCESS cycles with pready low before abort; 0 disables the timeout
CNT_WIDTH, 8, width of the wait counter; must satisfy TIMEOUT_CYCLES < 2**CNT_WIDTH

Ports:
pclk  in  1  clock; the block's only clock
presetn  in  1  asynchronous active-low reset
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid&ready
req_addr_i  in  ADDRESS_WIDTH  byte address
req_write_i  in  1  1=write, 0=read
req_wdata_i  in  DATA_WIDTH  write data
rsp_valid_o  out  1  one-cycle response pulse
rsp_rdata_o  out  DATA_WIDTH  read data (0 for writes/timeouts)
rsp_err_o  out  1  pslverr captured or timeout
rsp_timeout_o  out  1  transfer aborted by timeout
paddr  out  ADDRESS_WIDTH  APB address
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
pwdata  out  DATA_WIDTH  APB write data
pready  in  1  slave ready
prdata  in  DATA_WIDTH  slave read data
pslverr  in  1  slave error

Behaviour:
- Interface: one clock (pclk); reset is asynchronous and active-low (presetn).
- Reset values:
  - State IDLE.
  - psel=0, penable=0, pwrite=0, paddr=0, pwdata=0.
  - rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, rsp_timeout_o=0.
  - Wait counter=0.
- Reset asserted mid-transfer drops psel/penable immediately and asynchronously. No response is issued for the lost transfer.
- State machine: IDLE, SETUP, ACCESS.
  - IDLE: req_ready_o=1. On req_valid_i: register addr/write/wdata into paddr/pwrite/pwdata; next state SETUP.
  - SETUP: psel=1, penable=0; unconditionally next state ACCESS.
  - ACCESS: psel=1, penable=1.
    - pready=1: capture prdata (reads only, else 0) and pslverr; next state IDLE.
    - pready=0: increment wait counter. If TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: abort, rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0; next state IDLE.
- psel and penable are decoded from registered state only; no combinational path from req_* to any APB output.
- req_ready_o=0 in SETUP and ACCESS. Requests presented there are ignored until IDLE.
- paddr, pwrite and pwdata are stable from SETUP through the last ACCESS cycle. They keep their last values in IDLE; they are not zeroed.
- Response:
  - rsp_valid_o is registered, high exactly one cycle: the first IDLE cycle after completion.
  - rsp_rdata_o, rsp_err_o and rsp_timeout_o are valid with rsp_valid_o and hold until the next completion.
  - No backpressure on the response.
- Latency, zero-wait slave:
  - Accept edge at end of cycle 0; SETUP in cycle 1; ACCESS in cycle 2.
  - rsp_valid_o=1 in cycle 3.
  - N wait states add N cycles.
- Back-to-back: a new request may be accepted in the same cycle rsp_valid_o is high (IDLE). Minimum spacing is 3 cycles per transfer, with one psel-low cycle between transfers.
- Wait counter clears on entering SETUP. It saturates and never wraps (guaranteed by the parameter rule).
- Simultaneous pready=1 and timeout threshold in the same cycle: pready wins; normal completion with rsp_timeout_o=0.
- pslverr is sampled only when pready=1; ignored otherwise.

Test Plan:
- Write then read, zero-wait slave (apb_gpio at paddr 0x00):
  - req write 0x00/0x0000_00FF → psel rises cycle 1, penable cycle 2, rsp_valid_o cycle 3 with rsp_err_o=0; gpio_oe=0x0000_00FF.
  - Read 0x00 → rsp_rdata_o=0x0000_00FF.
- Wait states: slave holds pready=0 for 3 ACCESS cycles, read returns 0xDEAD_BEEF → paddr stable throughout, rsp_valid_o 6 cycles after accept, rsp_rdata_o=0xDEAD_BEEF.
- Slave error: pready=1 with pslverr=1 on a write → rsp_err_o=1, rsp_timeout_o=0, rsp_rdata_o=0.
- Timeout, TIMEOUT_CYCLES=4, pready stuck 0 → exactly 4 ACCESS cycles, then psel=0; rsp_valid_o with rsp_err_o=1, rsp_timeout_o=1.
- Timeout boundary, pready=1 on the 4th ACCESS cycle → normal completion, rsp_timeout_o=0.
- Back-to-back and reset:
  - req_valid_i held high for 3 writes → accepts every 3 cycles, psel low one cycle between transfers, 3 rsp pulses.
  - presetn pulsed low during ACCESS → psel/penable=0 asynchronously, no rsp_valid_o, next request completes normally.
